// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one instruction at a time, at most one bus transaction, single-cycle write-back beat.
// Optional misaligned-access trap enabled by defining YSYX_23060332_LSU_MISALIGN_CHECK_EN.
module ysyx_23060332_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_func3,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [4:0]        in_waddr,
    input  logic              in_wen,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [3:0]        mem_req_wmask,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [4:0]        wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Instruction fields latched at accept
    logic [2:0] func3_q, func3_d;
    logic [1:0] off_q, off_d;
    logic [4:0] waddr_q, waddr_d;
    logic       wen_q, wen_d;
    logic       load_q, load_d;

    // Next values of the registered outputs
    logic              ready_d;
    logic              req_valid_d;
    logic [ADDR_W-1:0] req_addr_d;
    logic              req_wen_d;
    logic [3:0]        req_wmask_d;
    logic [DATA_W-1:0] req_wdata_d;
    logic              wb_valid_d;
    logic              wb_wen_d;
    logic [4:0]        wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_d;
    logic              wb_err_d;

    logic              misal_c;

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] sd);
        case (f3)
            3'b000:  return {4{sd[7:0]}};
            3'b001:  return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // Pick the byte/half lane out of the returned word and extend it
    function automatic logic [DATA_W-1:0] load_format(input logic [2:0] f3,
                                                      input logic [1:0] off,
                                                      input logic [DATA_W-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
    // Unsupported func3 codes fall back to word access, so they are word-checked too
    function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic half;
        logic word;
        if (is_store) begin
            half = (f3 == 3'b001);
            word = (f3 != 3'b000) && (f3 != 3'b001);
        end else begin
            half = (f3[1:0] == 2'b01);
            word = f3[1];
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

    assign misal_c = (in_load || in_store) && misaligned(in_store, in_func3, in_result[1:0]);
`else
    assign misal_c = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        off_d       = off_q;
        waddr_d     = waddr_q;
        wen_d       = wen_q;
        load_d      = load_q;
        req_valid_d = 1'b0;
        req_addr_d  = mem_req_addr;
        req_wen_d   = mem_req_wen;
        req_wmask_d = mem_req_wmask;
        req_wdata_d = mem_req_wdata;
        wb_valid_d  = 1'b0;
        wb_wen_d    = wb_wen;
        wb_waddr_d  = wb_waddr;
        wb_wdata_d  = wb_wdata;
        wb_err_d    = wb_err;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    func3_d = in_func3;
                    off_d   = in_result[1:0];
                    waddr_d = in_waddr;
                    wen_d   = in_wen;
                    load_d  = in_load;
                    if (misal_c) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_waddr_d = in_waddr;
                        wb_wen_d   = 1'b0;
                        wb_wdata_d = '0;
                        wb_err_d   = 1'b1;
                    end else if (in_load || in_store) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = ADDR_W'({in_result[DATA_W-1:2], 2'b00});
                        req_wen_d   = in_store;
                        req_wmask_d = in_store ? store_mask(in_func3, in_result[1:0]) : 4'b0000;
                        req_wdata_d = in_store ? store_data(in_func3, in_sdata) : '0;
                    end else begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_waddr_d = in_waddr;
                        wb_wen_d   = in_wen;
                        wb_wdata_d = in_result;
                        wb_err_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_waddr_d = waddr_q;
                    wb_err_d   = mem_rsp_err;
                    wb_wen_d   = !mem_rsp_err && load_q && wen_q && (waddr_q != 5'd0);
                    wb_wdata_d = (mem_rsp_err || !load_q) ? '0
                                 : load_format(func3_q, off_q, mem_rsp_rdata);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            func3_q       <= 3'b000;
            off_q         <= 2'b00;
            waddr_q       <= 5'd0;
            wen_q         <= 1'b0;
            load_q        <= 1'b0;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wmask <= 4'b0000;
            mem_req_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_wen        <= 1'b0;
            wb_waddr      <= 5'd0;
            wb_wdata      <= '0;
            wb_err        <= 1'b0;
        end else begin
            state_q       <= state_d;
            func3_q       <= func3_d;
            off_q         <= off_d;
            waddr_q       <= waddr_d;
            wen_q         <= wen_d;
            load_q        <= load_d;
            in_ready      <= ready_d;
            mem_req_valid <= req_valid_d;
            mem_req_addr  <= req_addr_d;
            mem_req_wen   <= req_wen_d;
            mem_req_wmask <= req_wmask_d;
            mem_req_wdata <= req_wdata_d;
            wb_valid      <= wb_valid_d;
            wb_wen        <= wb_wen_d;
            wb_waddr      <= wb_waddr_d;
            wb_wdata      <= wb_wdata_d;
            wb_err        <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Scoreboard bench for ysyx_23060332_lsu: expected write-back beats are queued at issue and
// popped by a monitor; a small responder answers one cycle after each request handshake.
module tb_ysyx_23060332_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_func3;
    logic [31:0] in_result;
    logic [31:0] in_sdata;
    logic [4:0]  in_waddr;
    logic        in_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_err;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        logic        data_chk;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    int      cyc      = 0;
    int      wb_cnt   = 0;
    logic    auto_rsp;
    logic    inject_rsp;

    ysyx_23060332_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_load       (in_load),
        .in_store      (in_store),
        .in_func3      (in_func3),
        .in_result     (in_result),
        .in_sdata      (in_sdata),
        .in_waddr      (in_waddr),
        .in_wen        (in_wen),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wmask (mem_req_wmask),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_err   (mem_rsp_err),
        .wb_valid      (wb_valid),
        .wb_wen        (wb_wen),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .wb_err        (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: answer one cycle after the handshake, or when injected by the stimulus
    always @(posedge clk) begin
        mem_rsp_valid <= (auto_rsp && mem_req_valid && mem_req_ready) || inject_rsp;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: every write-back beat must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            wb_exp_t e;
            wb_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(wb_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_wen", 32'(wb_wen), 32'(e.wen));
                check_eq("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
                check_eq("wb_err", 32'(wb_err), 32'(e.err));
                if (e.data_chk) check_eq("wb_wdata", wb_wdata, e.wdata);
            end
        end
    end

    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] res, input logic [31:0] sd, input logic [4:0] wa,
                          input logic we, input logic [31:0] rd, input logic er, input int stall);
        wb_exp_t     e;
        logic        mis;
        logic        mem;
        logic        half;
        logic        word;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] fmt;
        logic [3:0]  em;
        logic [31:0] ed;
        int          n;
        int          t_acc;
        int          exp_lat;

        case (st ? {1'b0, f3} : {1'b1, f3})
            4'b0000, 4'b1000, 4'b1100: begin half = 1'b0; word = 1'b0; end
            4'b0001, 4'b1001, 4'b1101: begin half = 1'b1; word = 1'b0; end
            default:                   begin half = 1'b0; word = 1'b1; end
        endcase
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        mis = (ld || st) && ((half && res[0]) || (word && res[1:0] != 2'b00));
`else
        mis = 1'b0;
`endif
        mem = (ld || st) && !mis;

        b = 8'(rd >> {res[1:0], 3'b000});
        h = res[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  fmt = {{24{b[7]}}, b};
            3'b100:  fmt = {24'h0, b};
            3'b001:  fmt = {{16{h[15]}}, h};
            3'b101:  fmt = {16'h0, h};
            default: fmt = rd;
        endcase

        e.waddr = wa;
        e.data_chk = 1'b1;
        if (!ld && !st) begin
            e.wen = we; e.wdata = res; e.err = 1'b0;
        end else if (mis || er) begin
            e.wen = 1'b0; e.wdata = 32'h0; e.err = 1'b1;
        end else if (st) begin
            e.wen = 1'b0; e.wdata = 32'h0; e.err = 1'b0; e.data_chk = 1'b0;
        end else begin
            e.wen = we && (wa != 5'd0); e.wdata = fmt; e.err = 1'b0;
        end

        if (!st)            em = 4'b0000;
        else if (f3 == 3'd0) em = 4'b0001 << res[1:0];
        else if (f3 == 3'd1) em = res[1] ? 4'b1100 : 4'b0011;
        else                 em = 4'b1111;
        ed = (f3 == 3'd0) ? {4{sd[7:0]}} : (f3 == 3'd1) ? {2{sd[15:0]}} : sd;
        exp_lat = mem ? 3 + stall : 1;

        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        check_eq({tag, "_ready"}, 32'(in_ready), 32'(1));

        mem_rsp_rdata = rd;
        mem_rsp_err   = er;
        mem_req_ready = (stall == 0);
        in_valid  = 1'b1;
        in_load   = ld;
        in_store  = st;
        in_func3  = f3;
        in_result = res;
        in_sdata  = sd;
        in_waddr  = wa;
        in_wen    = we;
        exp_q.push_back(e);
        @(negedge clk);
        t_acc = cyc;
        in_valid = 1'b0;

        check_eq({tag, "_busy"}, 32'(in_ready), 32'(0));
        check_eq({tag, "_req_v"}, 32'(mem_req_valid), 32'(mem));
        if (mem) begin
            for (int i = 0; i <= stall; i++) begin
                if (i > 0) @(negedge clk);
                check_eq({tag, "_req_hold"}, 32'(mem_req_valid), 32'(1));
                check_eq({tag, "_req_addr"}, mem_req_addr, {res[31:2], 2'b00});
                check_eq({tag, "_req_wen"}, 32'(mem_req_wen), 32'(st));
                check_eq({tag, "_req_mask"}, 32'(mem_req_wmask), 32'(em));
                if (st) check_eq({tag, "_req_wdata"}, mem_req_wdata, ed);
            end
            mem_req_ready = 1'b1;
        end

        n = 0;
        while (!wb_valid && n < 20) begin @(negedge clk); n++; end
        check_eq({tag, "_lat"}, 32'(cyc - t_acc + 1), 32'(exp_lat));
        @(negedge clk);
        check_eq({tag, "_wb_pulse"}, 32'(wb_valid), 32'(0));
        check_eq({tag, "_ready_back"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int wb_before;
        logic mis_lw;

        rst = 1'b1;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_func3 = 3'd0;
        in_result = 32'h0; in_sdata = 32'h0; in_waddr = 5'd0; in_wen = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
        auto_rsp = 1'b1; inject_rsp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(in_ready), 32'(1));
        check_eq("rst_req_valid", 32'(mem_req_valid), 32'(0));
        check_eq("rst_req_addr", mem_req_addr, 32'h0);
        check_eq("rst_req_wen", 32'(mem_req_wen), 32'(0));
        check_eq("rst_req_mask", 32'(mem_req_wmask), 32'(0));
        check_eq("rst_req_wdata", mem_req_wdata, 32'h0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'(0));
        check_eq("rst_wb_wen", 32'(wb_wen), 32'(0));
        check_eq("rst_wb_waddr", 32'(wb_waddr), 32'(0));
        check_eq("rst_wb_wdata", wb_wdata, 32'h0);
        check_eq("rst_wb_err", 32'(wb_err), 32'(0));

        //      tag     ld    st    f3    result         sdata          wa  we    rdata          err   stall
        run_op("alu",   1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0,         5,  1'b1, 32'h0,         1'b0, 0);
        run_op("alu2",  1'b0, 1'b0, 3'd2, 32'hDEAD_BEEF, 32'h0,         7,  1'b0, 32'h0,         1'b0, 0);
        run_op("lb",    1'b1, 1'b0, 3'd0, 32'h8000_0003, 32'h0,         10, 1'b1, 32'h80FF_0000, 1'b0, 0);
        run_op("lbu",   1'b1, 1'b0, 3'd4, 32'h8000_0003, 32'h0,         11, 1'b1, 32'h80FF_0000, 1'b0, 0);
        run_op("lhu",   1'b1, 1'b0, 3'd5, 32'h8000_0002, 32'h0,         12, 1'b1, 32'h80FF_0000, 1'b0, 0);
        run_op("lh",    1'b1, 1'b0, 3'd1, 32'h8000_0002, 32'h0,         13, 1'b1, 32'h80FF_0000, 1'b0, 0);
        run_op("lbu1",  1'b1, 1'b0, 3'd4, 32'h8000_0001, 32'h0,         14, 1'b1, 32'hA5B6_C7D8, 1'b0, 0);
        run_op("lw",    1'b1, 1'b0, 3'd2, 32'h8000_0004, 32'h0,         15, 1'b1, 32'h1234_5678, 1'b0, 1);
        run_op("sb",    1'b0, 1'b1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 1,  1'b1, 32'h0,         1'b0, 3);
        run_op("sh",    1'b0, 1'b1, 3'd1, 32'h8000_0002, 32'h1234_CDEF, 2,  1'b1, 32'h0,         1'b0, 0);
        run_op("sw",    1'b0, 1'b1, 3'd2, 32'h8000_0008, 32'hCAFE_F00D, 3,  1'b1, 32'h0,         1'b0, 2);
        run_op("ld_x0", 1'b1, 1'b0, 3'd2, 32'h8000_0010, 32'h0,         0,  1'b1, 32'h7777_1111, 1'b0, 0);
        run_op("ld_err",1'b1, 1'b0, 3'd2, 32'h8000_000C, 32'h0,         9,  1'b1, 32'h0000_0055, 1'b1, 0);
        run_op("lw_mis",1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0,         6,  1'b1, 32'hAABB_CCDD, 1'b0, 0);
        run_op("sh_mis",1'b0, 1'b1, 3'd1, 32'h8000_0001, 32'h0000_5A5A, 4,  1'b1, 32'h0,         1'b0, 0);

        for (int k = 0; k < 16; k++) begin
            int op;
            op = $urandom_range(0, 2);
            run_op("rand", op == 1, op == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 2));
        end

        // Reset while a request is stalled drops mem_req_valid
        mem_req_ready = 1'b0;
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_func3 = 3'd2;
        in_result = 32'h8000_0020; in_waddr = 5'd8; in_wen = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("rstreq_valid", 32'(mem_req_valid), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstreq_drop", 32'(mem_req_valid), 32'(0));
        check_eq("rstreq_ready", 32'(in_ready), 32'(1));
        mem_req_ready = 1'b1;

        // Reset in WAIT; a late response to the aborted request must be ignored
        auto_rsp = 1'b0;
        wb_before = wb_cnt;
        in_valid = 1'b1; in_load = 1'b1; in_func3 = 3'd2; in_result = 32'h8000_0010; in_waddr = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rstwait_hs_done", 32'(mem_req_valid), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstwait_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        inject_rsp = 1'b1;
        @(negedge clk);
        inject_rsp = 1'b0;
        check_eq("rstwait_rsp_seen", 32'(mem_rsp_valid), 32'(1));
        repeat (2) @(negedge clk);
        check_eq("rstwait_no_wb", 32'(wb_cnt), 32'(wb_before));
        check_eq("rstwait_idle", 32'(in_ready), 32'(1));
        auto_rsp = 1'b1;

        // After the aborted transaction the unit must still work normally
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        mis_lw = 1'b1;
`else
        mis_lw = 1'b0;
`endif
        run_op("post_rst", 1'b1, 1'b0, 3'd2, 32'h8000_0002, 32'h0, 21, 1'b1, 32'h0BAD_F00D, 1'b0, 0);
        check_eq("post_rst_err", 32'(wb_err), 32'(mis_lw));

        check_eq("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
